dbg_tx_sched: RTL and testbench

Packet-atomic scheduler for the debug UART transmit path. It shares the single send FIFO (8-bit write port, `HasSpace` flow control) between several byte-stream sources: the command responder, the attention generator, the ADC/log-timer streamer and the sideband channel. Once a source wins a grant it owns the FIFO until its last byte is written, so packets never interleave. A per-grant stall timer frees the FIFO from a source that stops supplying bytes.

---
 rtl/dbg_tx_pkg.sv | 14 +
 rtl/dbg_tx_sched_if.sv | 29 ++
 rtl/dbg_rr_pick.sv | 45 ++++
 rtl/dbg_tx_sched.sv | 119 +++++++++++
 tb/tb_dbg_tx_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_tx_pkg.sv
// Shared types and constants for the debug UART transmit scheduler.
// Holds the FSM state encoding, the default source count and the stall timer width.
package dbg_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_REL  = 2'd2
    } tx_state_e;

    localparam int CSrcCntDef = 4;
    localparam int TimerW     = 10;

endpackage

// File: rtl/dbg_tx_sched_if.sv
// Bundle between the byte-stream sources, the scheduler and the send FIFO.
// master: scheduler side (drives AAck/AGnt/AAbort/ASend*/ABusy); slave: sources + FIFO.
interface dbg_tx_sched_if
    import dbg_tx_pkg::*;
#(
    parameter int CSrcCnt = CSrcCntDef
);
    logic [CSrcCnt-1:0]   AReq;
    logic [CSrcCnt-1:0]   AValid;
    logic [8*CSrcCnt-1:0] AData;
    logic [CSrcCnt-1:0]   ALast;
    logic [CSrcCnt-1:0]   AAck;
    logic [CSrcCnt-1:0]   AGnt;
    logic [CSrcCnt-1:0]   AAbort;
    logic [7:0]           ASendData;
    logic                 ASendNow;
    logic                 ASendHasSpace;
    logic                 ABusy;

    modport master (
        input  AReq, AValid, AData, ALast, ASendHasSpace,
        output AAck, AGnt, AAbort, ASendData, ASendNow, ABusy
    );

    modport slave (
        output AReq, AValid, AData, ALast, ASendHasSpace,
        input  AAck, AGnt, AAbort, ASendData, ASendNow, ABusy
    );
endinterface

// File: rtl/dbg_rr_pick.sv
// Combinational picker: lowest-index requester in the priority mask wins,
// otherwise first non-priority requester at/after ptr (wrapping). Ports: req, prio, ptr -> win (one-hot), any.
module dbg_rr_pick
    import dbg_tx_pkg::*;
#(
    parameter int N = CSrcCntDef
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         prio,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         win,
    output logic                 any
);
    logic [N-1:0] pr;
    logic [N-1:0] rr;
    logic         found;
    int           idx;

    assign pr  = req & prio;
    assign rr  = req & ~prio;
    assign any = |req;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (|pr) begin
            for (int i = 0; i < N; i++) begin
                if (pr[i] && !found) begin
                    win[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (rr[idx] && !found) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/dbg_tx_sched.sv
// Packet-atomic scheduler sharing one send FIFO among CSrcCnt byte sources, with stall timeout.
// Ports: AClkH, AResetH (sync, high), AClkHEn, ASync1K (1 ms tick), bus (master modport).
module dbg_tx_sched
    import dbg_tx_pkg::*;
#(
    parameter int                 CSrcCnt   = CSrcCntDef,
    parameter logic [CSrcCnt-1:0] CPrioMask = CSrcCnt'(4'b0001),
    parameter int                 CTimeOut  = 10
) (
    input logic            AClkH,
    input logic            AResetH,
    input logic            AClkHEn,
    input logic            ASync1K,
    dbg_tx_sched_if.master bus
);
    localparam int PW = $clog2(CSrcCnt);
    localparam logic [TimerW-1:0] TLoad = TimerW'(CTimeOut);

    tx_state_e           state_q, state_d;
    logic [CSrcCnt-1:0]  gnt_q, gnt_d;
    logic [CSrcCnt-1:0]  abort_q, abort_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [TimerW-1:0]   tmr_q, tmr_d;

    logic [CSrcCnt-1:0]  win;
    logic                any_req;
    logic [PW-1:0]       widx;
    logic [7:0]          gdata;
    logic                g_valid;
    logic                g_last;
    logic                xfer;

    dbg_rr_pick #(.N(CSrcCnt)) u_pick (
        .req  (bus.AReq),
        .prio (CPrioMask),
        .ptr  (ptr_q),
        .win  (win),
        .any  (any_req)
    );

    always_comb begin
        widx  = '0;
        gdata = '0;
        for (int i = 0; i < CSrcCnt; i++) begin
            if (win[i])   widx  = PW'(i);
            if (gnt_q[i]) gdata = bus.AData[8*i +: 8];
        end
    end

    assign g_valid = |(gnt_q & bus.AValid);
    assign g_last  = |(gnt_q & bus.ALast);

    // An expired timer wins over a late byte so an abort never races an ack.
    assign xfer = AClkHEn && (state_q == ST_XFER) && (tmr_q != '0)
                  && g_valid && bus.ASendHasSpace;

    assign bus.ASendNow  = xfer;
    assign bus.ASendData = xfer ? gdata : 8'h00;
    assign bus.AAck      = xfer ? gnt_q : '0;
    assign bus.AGnt      = gnt_q;
    assign bus.AAbort    = abort_q;
    assign bus.ABusy     = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        abort_d = '0;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = win;
                    tmr_d   = TLoad;
                    state_d = ST_XFER;
                    if (!(|(win & CPrioMask))) begin
                        ptr_d = (widx == PW'(CSrcCnt - 1)) ? '0 : widx + PW'(1);
                    end
                end
            end
            ST_XFER: begin
                if (xfer) begin
                    tmr_d = TLoad;
                    if (g_last) state_d = ST_REL;
                end else if (tmr_q == '0) begin
                    abort_d = gnt_q;
                    state_d = ST_REL;
                end else if (ASync1K && !g_valid) begin
                    // Only a silent source ages the timer; FIFO-full stalls do not.
                    tmr_d = tmr_q - TimerW'(1);
                end
            end
            ST_REL: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            abort_q <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
        end else if (AClkHEn) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
        end
    end
endmodule

// File: tb/tb_dbg_tx_sched.sv
// Directed self-checking bench for dbg_tx_sched (4 sources, source 0 priority, 3 ms timeout).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dbg_tx_sched;
    import dbg_tx_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic sync;

    int checks   = 0;
    int failures = 0;

    int         srcq[$];
    logic [7:0] datq[$];

    dbg_tx_sched_if #(.CSrcCnt(4)) bus ();

    dbg_tx_sched #(
        .CSrcCnt   (4),
        .CPrioMask (4'b0001),
        .CTimeOut  (3)
    ) dut (
        .AClkH   (clk),
        .AResetH (rst),
        .AClkHEn (en),
        .ASync1K (sync),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_byte(input int s, input logic [7:0] d);
        bus.AData[8*s +: 8] = d;
    endtask

    task automatic clear_src();
        bus.AReq   = '0;
        bus.AValid = '0;
        bus.ALast  = '0;
        bus.AData  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_src();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Every requester offers a one-byte packet 0x10+s; records ack order.
    task automatic serve(input logic [3:0] req, input int maxcyc);
        logic [3:0] pend;
        pend = req;
        srcq.delete();
        datq.delete();
        @(negedge clk);
        bus.AReq   = pend;
        bus.AValid = pend;
        bus.ALast  = pend;
        for (int s = 0; s < 4; s++) set_byte(s, 8'(16 + s));
        for (int c = 0; c < maxcyc && pend != 0; c++) begin
            #1;
            if (bus.ASendNow) begin
                for (int s = 0; s < 4; s++) begin
                    if (bus.AAck[s]) begin
                        srcq.push_back(s);
                        datq.push_back(bus.ASendData);
                        pend[s] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            bus.AReq   = pend;
            bus.AValid = pend;
            bus.ALast  = pend;
        end
        clear_src();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=0000", bus.AGnt);
        end
        checks++;
        if (bus.ABusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.ABusy);
        end
        checks++;
        if (bus.ASendNow !== 1'b0 || bus.ASendData !== 8'h00) begin
            failures++;
            $display("FAIL reset_send got=%b/%h exp=0/00", bus.ASendNow, bus.ASendData);
        end
        checks++;
        if (bus.AAck !== 4'b0000 || bus.AAbort !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack_abort got=%b/%b exp=0000/0000", bus.AAck, bus.AAbort);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        exp_d = '{8'hA1, 8'hA2, 8'hA3};
        @(negedge clk);
        bus.AReq = 4'b0100;
        #1;
        checks++;
        if (bus.ASendNow !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_send got=%b exp=0", bus.ASendNow);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.AReq      = 4'b0000;
            bus.AValid[2] = 1'b1;
            bus.ALast[2]  = (i == 2);
            set_byte(2, exp_d[i]);
            #1;
            checks++;
            if (bus.AGnt !== 4'b0100) begin
                failures++;
                $display("FAIL single_gnt%0d got=%b exp=0100", i, bus.AGnt);
            end
            checks++;
            if (bus.ASendNow !== 1'b1 || bus.ASendData !== exp_d[i]) begin
                failures++;
                $display("FAIL single_byte%0d got=%b/%h exp=1/%h",
                         i, bus.ASendNow, bus.ASendData, exp_d[i]);
            end
            checks++;
            if (bus.AAck !== 4'b0100) begin
                failures++;
                $display("FAIL single_ack%0d got=%b exp=0100", i, bus.AAck);
            end
        end
        @(negedge clk);
        clear_src();
        #1;
        checks++;
        if (bus.ASendNow !== 1'b0 || bus.ABusy !== 1'b1) begin
            failures++;
            $display("FAIL single_release got=%b/%b exp=0/1", bus.ASendNow, bus.ABusy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.ABusy !== 1'b0 || bus.AGnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle got=%b/%b exp=0/0000", bus.ABusy, bus.AGnt);
        end
    endtask

    task automatic test_prio_rr();
        int exp_s [3];
        exp_s = '{0, 1, 3};
        do_reset();
        serve(4'b1011, 40);
        checks++;
        if (srcq.size() != 3) begin
            failures++;
            $display("FAIL prio_count got=%0d exp=3", srcq.size());
        end
        for (int i = 0; i < srcq.size() && i < 3; i++) begin
            checks++;
            if (srcq[i] != exp_s[i] || datq[i] !== 8'(16 + exp_s[i])) begin
                failures++;
                $display("FAIL prio_order%0d got=%0d/%h exp=%0d/%h",
                         i, srcq[i], datq[i], exp_s[i], 8'(16 + exp_s[i]));
            end
        end
        serve(4'b1010, 40);
        checks++;
        if (srcq.size() != 2 || srcq[0] != 1) begin
            failures++;
            $display("FAIL rr_wrap got=%0d(n=%0d) exp=1",
                     (srcq.size() > 0) ? srcq[0] : -1, srcq.size());
        end
    endtask

    task automatic test_atomic();
        logic [7:0] d1 [3];
        d1 = '{8'h31, 8'h32, 8'h33};
        @(negedge clk);
        bus.AReq = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.AValid[1] = 1'b1;
            bus.ALast[1]  = (i == 2);
            set_byte(1, d1[i]);
            if (i == 1) begin
                bus.AReq[0]   = 1'b1;
                bus.AValid[0] = 1'b1;
                bus.ALast[0]  = 1'b1;
                set_byte(0, 8'h40);
            end
            #1;
            checks++;
            if (bus.AAck !== 4'b0010 || bus.ASendData !== d1[i]) begin
                failures++;
                $display("FAIL atomic_src1_%0d got=%b/%h exp=0010/%h",
                         i, bus.AAck, bus.ASendData, d1[i]);
            end
        end
        @(negedge clk);
        bus.AReq[1]   = 1'b0;
        bus.AValid[1] = 1'b0;
        bus.ALast[1]  = 1'b0;
        #1;
        checks++;
        if (bus.ASendNow !== 1'b0) begin
            failures++;
            $display("FAIL atomic_release_send got=%b exp=0", bus.ASendNow);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0000 || bus.ASendNow !== 1'b0) begin
            failures++;
            $display("FAIL atomic_idle got=%b/%b exp=0000/0", bus.AGnt, bus.ASendNow);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0001 || bus.AAck !== 4'b0001 || bus.ASendData !== 8'h40) begin
            failures++;
            $display("FAIL atomic_src0 got=%b/%b/%h exp=0001/0001/40",
                     bus.AGnt, bus.AAck, bus.ASendData);
        end
        @(negedge clk);
        clear_src();
    endtask

    task automatic test_backpressure();
        int   k;
        logic hs;
        @(negedge clk);
        bus.AReq = 4'b0100;
        @(negedge clk);
        bus.AReq             = 4'b0000;
        bus.AValid[2]        = 1'b1;
        bus.ASendHasSpace    = 1'b0;
        sync                 = 1'b1;
        set_byte(2, 8'h80);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (bus.ASendNow !== 1'b0 || bus.AAbort !== 4'b0000 || bus.AGnt !== 4'b0100) begin
                failures++;
                $display("FAIL bp_full%0d got=%b/%b/%b exp=0/0000/0100",
                         i, bus.ASendNow, bus.AAbort, bus.AGnt);
            end
            @(negedge clk);
        end
        k  = 0;
        hs = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            bus.ASendHasSpace = hs;
            sync              = ~hs;
            bus.ALast[2]      = (k == 7);
            set_byte(2, 8'(8'h80 + k));
            #1;
            checks++;
            if (bus.ASendNow !== hs || bus.AAck !== (hs ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL bp_strobe%0d got=%b/%b exp=%b", c, bus.ASendNow, bus.AAck, hs);
            end
            if (hs) begin
                checks++;
                if (bus.ASendData !== 8'(8'h80 + k)) begin
                    failures++;
                    $display("FAIL bp_data%0d got=%h exp=%h", k, bus.ASendData, 8'(8'h80 + k));
                end
                k++;
            end
            hs = ~hs;
            @(negedge clk);
        end
        checks++;
        if (k != 8) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=8", k);
        end
        clear_src();
        bus.ASendHasSpace = 1'b1;
        sync              = 1'b0;
    endtask

    task automatic test_timeout();
        int ticks;
        bit got;
        @(negedge clk);
        bus.AReq = 4'b1000;
        @(negedge clk);
        bus.AReq      = 4'b1010;
        bus.AValid[3] = 1'b1;
        set_byte(3, 8'h5A);
        #1;
        checks++;
        if (bus.AGnt !== 4'b1000 || bus.AAck !== 4'b1000 || bus.ASendData !== 8'h5A) begin
            failures++;
            $display("FAIL to_first got=%b/%b/%h exp=1000/1000/5a",
                     bus.AGnt, bus.AAck, bus.ASendData);
        end
        @(negedge clk);
        bus.AValid[3] = 1'b0;
        ticks = 0;
        got   = 1'b0;
        for (int c = 0; c < 24 && !got; c++) begin
            sync = (c % 4 == 3);
            #1;
            if (bus.AAbort != 4'b0000) begin
                got = 1'b1;
            end else begin
                if (sync) ticks++;
                @(negedge clk);
            end
        end
        sync = 1'b0;
        checks++;
        if (!got || bus.AAbort !== 4'b1000 || ticks != 3) begin
            failures++;
            $display("FAIL to_abort got=%b ticks=%0d exp=1000 ticks=3", bus.AAbort, ticks);
        end
        bus.AReq[3] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0000 || bus.AAbort !== 4'b0000) begin
            failures++;
            $display("FAIL to_clear got=%b/%b exp=0000/0000", bus.AGnt, bus.AAbort);
        end
        @(negedge clk);
        bus.AValid[1] = 1'b1;
        bus.ALast[1]  = 1'b1;
        set_byte(1, 8'h66);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0010 || bus.AAck !== 4'b0010 || bus.ASendData !== 8'h66) begin
            failures++;
            $display("FAIL to_next got=%b/%b/%h exp=0010/0010/66",
                     bus.AGnt, bus.AAck, bus.ASendData);
        end
        @(negedge clk);
        clear_src();
    endtask

    task automatic test_reset_clken();
        @(negedge clk);
        @(negedge clk);
        bus.AReq = 4'b0100;
        @(negedge clk);
        bus.AReq      = 4'b0000;
        bus.AValid[2] = 1'b1;
        set_byte(2, 8'hC1);
        #1;
        checks++;
        if (bus.ASendNow !== 1'b1 || bus.ASendData !== 8'hC1) begin
            failures++;
            $display("FAIL en_first got=%b/%h exp=1/c1", bus.ASendNow, bus.ASendData);
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.AValid[2] = (i == 4);
            sync          = (i < 4);
            set_byte(2, 8'hC2);
            #1;
            checks++;
            if (bus.ASendNow !== 1'b0 || bus.AAck !== 4'b0000 || bus.AGnt !== 4'b0100) begin
                failures++;
                $display("FAIL en_hold%0d got=%b/%b/%b exp=0/0000/0100",
                         i, bus.ASendNow, bus.AAck, bus.AGnt);
            end
            @(negedge clk);
        end
        en            = 1'b1;
        sync          = 1'b0;
        bus.AValid[2] = 1'b1;
        #1;
        checks++;
        if (bus.ASendNow !== 1'b1 || bus.ASendData !== 8'hC2 || bus.AAbort !== 4'b0000) begin
            failures++;
            $display("FAIL en_resume got=%b/%h/%b exp=1/c2/0000",
                     bus.ASendNow, bus.ASendData, bus.AAbort);
        end
        @(negedge clk);
        rst = 1'b1;
        set_byte(2, 8'hC3);
        @(negedge clk);
        #1;
        checks++;
        if (bus.AGnt !== 4'b0000 || bus.ABusy !== 1'b0 || bus.AAbort !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_state got=%b/%b/%b exp=0000/0/0000",
                     bus.AGnt, bus.ABusy, bus.AAbort);
        end
        checks++;
        if (bus.ASendNow !== 1'b0 || bus.ASendData !== 8'h00 || bus.AAck !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_send got=%b/%h/%b exp=0/00/0000",
                     bus.ASendNow, bus.ASendData, bus.AAck);
        end
        rst = 1'b0;
        clear_src();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        sync = 1'b0;
        clear_src();
        bus.ASendHasSpace = 1'b1;
        test_reset();
        test_single();
        test_prio_rr();
        test_atomic();
        test_backpressure();
        test_timeout();
        test_reset_clken();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
